// File: rtl/zynet_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : zynet_frame_sequencer
// Description : Frame-level controller for the zyNet classifier. Pulses the
//               network start, streams one frame of source words into it,
//               waits (bounded) for the score vector, scans it for the
//               signed argmax and holds scores plus class for the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module zynet_frame_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int OUTPUT_SIZE    = 10,
  parameter int FRAME_LEN      = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   frame_go_i,
  input  logic                                   clear_i,
  input  logic [WORD_SIZE-1:0]                   src_data_i,
  input  logic                                   src_valid_i,
  output logic                                   src_ready_o,
  output logic                                   net_start_o,
  output logic [WORD_SIZE-1:0]                   net_data_o,
  output logic                                   net_valid_o,
  input  logic                                   net_ready_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]       net_data_i,
  input  logic                                   net_valid_i,
  output logic                                   net_yumi_o,
  output logic [OUTPUT_SIZE*WORD_SIZE-1:0]       res_data_o,
  output logic [((OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1)-1:0] res_class_o,
  output logic                                   res_valid_o,
  input  logic                                   res_yumi_i,
  output logic                                   busy_o,
  output logic                                   timeout_o,
  output logic [15:0]                            frame_count_o
);

  localparam int c_cls_w  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int c_word_w = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int c_tmo_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(FRAME_LEN - 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cls_w-1:0]  c_idx_last  = c_cls_w'(OUTPUT_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ARGMAX = 3'd4,
    ST_HOLD   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  state_e                                  state_q;
  logic [c_word_w-1:0]                     word_cnt_q;
  logic [c_tmo_w-1:0]                      tmo_cnt_q;
  logic [c_cls_w-1:0]                      scan_idx_q;
  logic [c_cls_w-1:0]                      best_idx_q;
  logic signed [WORD_SIZE-1:0]             best_val_q;
  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]   res_q;
  logic [15:0]                             frame_cnt_q;

  logic                                    w_in_stream;
  logic                                    w_drain_net;
  logic                                    w_xfer;
  logic signed [WORD_SIZE-1:0]             w_elem;

  // The source is wired straight through to the network only while streaming,
  // so no word can leak across a frame boundary.
  assign w_in_stream = (state_q == ST_STREAM);
  assign w_drain_net = (state_q == ST_WAIT) || (state_q == ST_ERR);
  assign w_xfer      = w_in_stream & src_valid_i & net_ready_i;
  assign w_elem      = res_q[scan_idx_q];

  assign src_ready_o   = w_in_stream & net_ready_i;
  assign net_valid_o   = w_in_stream & src_valid_i;
  assign net_data_o    = w_in_stream ? src_data_i : '0;
  assign net_yumi_o    = w_drain_net & net_valid_i;
  assign net_start_o   = (state_q == ST_START);
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_o     = (state_q == ST_ERR);
  assign res_valid_o   = (state_q == ST_HOLD);
  assign res_data_o    = res_q;
  assign res_class_o   = best_idx_q;
  assign frame_count_o = frame_cnt_q;

  // Frame sequencing, word/timeout counters, score capture and argmax scan.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      res_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_go_i) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          word_cnt_q <= '0;
          state_q    <= ST_STREAM;
        end

        ST_STREAM: begin
          if (w_xfer) begin
            word_cnt_q <= word_cnt_q + c_word_w'(1);
            if (word_cnt_q == c_word_last) begin
              tmo_cnt_q <= '0;
              state_q   <= ST_WAIT;
            end
          end
        end

        // A vector arriving on the last permitted cycle still counts.
        ST_WAIT: begin
          if (net_valid_i) begin
            res_q      <= net_data_i;
            best_idx_q <= '0;
            best_val_q <= net_data_i[WORD_SIZE-1:0];
            scan_idx_q <= c_cls_w'(1);
            state_q    <= ST_ARGMAX;
          end else if (tmo_cnt_q == c_tmo_last) begin
            state_q <= ST_ERR;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + c_tmo_w'(1);
          end
        end

        // Strict greater-than keeps the lowest index among equal maxima.
        ST_ARGMAX: begin
          if (w_elem > best_val_q) begin
            best_val_q <= w_elem;
            best_idx_q <= scan_idx_q;
          end
          if (scan_idx_q == c_idx_last) begin
            state_q <= ST_HOLD;
          end else begin
            scan_idx_q <= scan_idx_q + c_cls_w'(1);
          end
        end

        ST_HOLD: begin
          if (res_yumi_i) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= ST_IDLE;
          end
        end

        ST_ERR: begin
          if (clear_i) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zynet_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_zynet_frame_sequencer
// Description : Scoreboard bench for zynet_frame_sequencer with randomized
//               source/network behaviour and a reference argmax model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zynet_frame_sequencer;

  localparam int WS  = 16;
  localparam int OS  = 10;
  localparam int FL  = 256;
  localparam int TMO = 16;
  localparam int CW  = $clog2(OS);
  localparam int VW  = OS * WS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          frame_go;
  logic          clear;
  logic [WS-1:0] src_data;
  logic          src_valid;
  logic          src_ready_o;
  logic          net_start_o;
  logic [WS-1:0] net_data_o;
  logic          net_valid_o;
  logic          net_ready;
  logic [VW-1:0] net_data;
  logic          net_valid;
  logic          net_yumi_o;
  logic [VW-1:0] res_data_o;
  logic [CW-1:0] res_class_o;
  logic          res_valid_o;
  logic          res_yumi;
  logic          busy_o;
  logic          timeout_o;
  logic [15:0]   frame_count_o;

  zynet_frame_sequencer #(
    .WORD_SIZE      (WS),
    .OUTPUT_SIZE    (OS),
    .FRAME_LEN      (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_n),
    .frame_go_i    (frame_go),
    .clear_i       (clear),
    .src_data_i    (src_data),
    .src_valid_i   (src_valid),
    .src_ready_o   (src_ready_o),
    .net_start_o   (net_start_o),
    .net_data_o    (net_data_o),
    .net_valid_o   (net_valid_o),
    .net_ready_i   (net_ready),
    .net_data_i    (net_data),
    .net_valid_i   (net_valid),
    .net_yumi_o    (net_yumi_o),
    .res_data_o    (res_data_o),
    .res_class_o   (res_class_o),
    .res_valid_o   (res_valid_o),
    .res_yumi_i    (res_yumi),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .frame_count_o (frame_count_o)
  );

  typedef struct {
    logic [CW-1:0] cls;
    logic [VW-1:0] scores;
  } res_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WS-1:0] exp_word_q[$];
  res_t          exp_res_q[$];

  // Controls written only by the main sequence
  int   src_budget  = 0;
  int   net_mode    = 0;   // 0: network answers, 1: network silent
  bit   ready_rand  = 1'b0;
  int   score_mode  = 0;   // 0: random, 1: max 0x0400 at idx 7, 2: negative ties
  int   late_req    = 0;

  // Written only by the monitor
  int   mon_xfer      = 0;
  int   last_xfer_cyc = 0;

  int tie_pat [OS] = '{-5, -1, -1, -3, -2, -7, -4, -8, -6, -9};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scores for one frame, according to the requested pattern
  function automatic logic [VW-1:0] make_scores(input int mode);
    logic [VW-1:0] v;
    logic [WS-1:0] e;
    v = '0;
    for (int i = 0; i < OS; i++) begin
      case (mode)
        1:       e = (i == 7) ? 16'h0400 : WS'($urandom_range(0, 16'h07FF)) - 16'h0400;
        2:       e = WS'(tie_pat[i]);
        default: e = ($urandom_range(0, 1) == 1) ? WS'($urandom) : WS'($urandom_range(0, 6)) - 16'd3;
      endcase
      v[i*WS +: WS] = e;
    end
    return v;
  endfunction

  // Reference class: the maximum signed value, then the lowest index holding it
  function automatic logic [CW-1:0] ref_argmax(input logic [VW-1:0] v);
    int mx;
    int idx;
    mx = int'($signed(v[WS-1:0]));
    for (int i = 1; i < OS; i++)
      if (int'($signed(v[i*WS +: WS])) > mx) mx = int'($signed(v[i*WS +: WS]));
    idx = 0;
    for (int i = OS - 1; i >= 0; i--)
      if (int'($signed(v[i*WS +: WS])) == mx) idx = i;
    return CW'(idx);
  endfunction

  // Source: offers words with random gaps, one outstanding at a time
  initial begin : src_model
    bit taken;
    int offered;
    offered   = 0;
    src_valid = 1'b0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      taken = src_valid && src_ready_o;
      @(posedge clk); #1;
      if (!reset_n) begin
        src_valid = 1'b0;
        offered   = src_budget;
      end else begin
        if (taken) src_valid = 1'b0;
        if (!src_valid && offered < src_budget && $urandom_range(0, 3) != 0) begin
          src_data  = WS'($urandom);
          src_valid = 1'b1;
          offered++;
          exp_word_q.push_back(src_data);
        end
      end
    end
  end

  // Network: random ready, answers a full frame after a short random delay
  initial begin : net_model
    bit start_seen, yumi_seen, xfer_seen;
    int rx, dly, late_done;
    logic [VW-1:0] s;
    res_t r;
    rx = 0; dly = -1; late_done = 0;
    net_valid = 1'b0;
    net_data  = '0;
    net_ready = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = net_start_o;
      yumi_seen  = net_valid && net_yumi_o;
      xfer_seen  = net_valid_o && net_ready;
      @(posedge clk); #1;
      if (!reset_n) begin
        rx = 0; dly = -1;
        net_valid = 1'b0;
        net_ready = 1'b0;
        late_done = late_req;
      end else begin
        if (start_seen) rx = 0;
        if (xfer_seen) rx++;
        if (yumi_seen) net_valid = 1'b0;
        net_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (xfer_seen && rx == FL && net_mode == 0) dly = $urandom_range(0, 10);
        if (dly == 0) begin
          s         = make_scores(score_mode);
          net_data  = s;
          net_valid = 1'b1;
          r.cls     = ref_argmax(s);
          r.scores  = s;
          exp_res_q.push_back(r);
          dly = -1;
        end else if (dly > 0) begin
          dly--;
        end
        if (late_done != late_req) begin
          net_data  = make_scores(0);
          net_valid = 1'b1;
          late_done++;
        end
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents data
  initial begin : monitor
    int start_cnt, cap_cyc;
    bit prev_start, prev_rv, fc_pending;
    logic [15:0]   exp_fc;
    logic [VW-1:0] hold_data;
    logic [CW-1:0] hold_cls;
    logic [WS-1:0] w;
    res_t r;
    start_cnt = 0; cap_cyc = 0; prev_start = 0; prev_rv = 0; fc_pending = 0;
    exp_fc = '0; hold_data = '0; hold_cls = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_word_q.delete();
        exp_res_q.delete();
        mon_xfer = 0; start_cnt = 0; exp_fc = '0;
        prev_start = 0; prev_rv = 0; fc_pending = 0;
      end else begin
        if (fc_pending) begin
          check("frame_count_after_yumi", 256'(frame_count_o), 256'(exp_fc));
          fc_pending = 0;
        end
        if (net_start_o) begin
          check("start_pulse_width", 256'(prev_start), 256'(0));
          start_cnt++;
          mon_xfer = 0;
        end
        if ((src_valid && src_ready_o) || (net_valid_o && net_ready))
          check("handshake_pass", 256'(src_valid && src_ready_o), 256'(net_valid_o && net_ready));
        if (net_valid_o && net_ready) begin
          mon_xfer++;
          last_xfer_cyc = cyc;
          if (exp_word_q.size() == 0) begin
            check("word_queue_nonempty", 256'(0), 256'(1));
          end else begin
            w = exp_word_q.pop_front();
            check("stream_word", 256'(net_data_o), 256'(w));
          end
        end
        if (timeout_o) start_cnt = 0;
        if (net_valid && net_yumi_o && !timeout_o) begin
          check("words_per_frame", 256'(mon_xfer), 256'(FL));
          check("starts_per_frame", 256'(start_cnt), 256'(1));
          start_cnt = 0;
          cap_cyc = cyc;
        end
        if (res_valid_o && !prev_rv) begin
          check("result_latency", 256'(cyc - cap_cyc - 1), 256'(OS - 1));
          check("frame_count_hold", 256'(frame_count_o), 256'(exp_fc));
          if (exp_res_q.size() == 0) begin
            check("result_queue_nonempty", 256'(0), 256'(1));
          end else begin
            r = exp_res_q.pop_front();
            check("res_class", 256'(res_class_o), 256'(r.cls));
            check("res_data", 256'(res_data_o), 256'(r.scores));
          end
          hold_data = res_data_o;
          hold_cls  = res_class_o;
        end else if (res_valid_o) begin
          check("hold_data_stable", 256'(res_data_o), 256'(hold_data));
          check("hold_class_stable", 256'(res_class_o), 256'(hold_cls));
        end
        if (res_valid_o && res_yumi) begin
          exp_fc = exp_fc + 16'd1;
          fc_pending = 1;
        end
        prev_start = net_start_o;
        prev_rv    = res_valid_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [255:0] all_outputs();
    return 256'({net_start_o, net_valid_o, src_ready_o, net_yumi_o, busy_o, timeout_o,
                 res_valid_o, frame_count_o, res_class_o, net_data_o, res_data_o});
  endfunction

  logic [15:0] frames_done = '0;

  // One frame: request, wait for result, optionally hold it, then take it
  task automatic run_frame(input int hold, input bit go_in_hold, input int exp_cls);
    int n;
    tick();
    frame_go   = 1'b1;
    src_budget = src_budget + FL + $urandom_range(0, 2);
    tick();
    frame_go = 1'b0;
    n = 0;
    while (!res_valid_o && n < 3000) begin
      tick();
      n++;
    end
    check("result_arrives", 256'(res_valid_o), 256'(1));
    if (!res_valid_o) return;
    if (exp_cls >= 0) check("directed_class", 256'(res_class_o), 256'(exp_cls));
    for (int i = 0; i < hold; i++) begin
      frame_go = (go_in_hold && i == 5);
      clear    = (go_in_hold && i == 8);
      tick();
    end
    frame_go = 1'b0;
    clear    = 1'b0;
    res_yumi = 1'b1;
    tick();
    res_yumi = 1'b0;
    frames_done = frames_done + 16'd1;
    check("idle_after_yumi", 256'(busy_o), 256'(0));
    if (go_in_hold) begin
      repeat (4) tick();
      check("no_queued_frame", 256'(busy_o), 256'(0));
    end
  endtask

  initial begin : main
    int n;
    reset_n  = 1'b0;
    frame_go = 1'b0;
    clear    = 1'b0;
    res_yumi = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outputs(), 256'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Nominal frame, always-ready network
    ready_rand = 1'b0;
    score_mode = 1;
    run_frame(2, 1'b0, 7);

    // Back-pressured network, random scores
    ready_rand = 1'b1;
    score_mode = 0;
    for (int f = 0; f < 4; f++) run_frame(int'($urandom_range(0, 3)), 1'b0, -1);

    // Negative scores with ties
    score_mode = 2;
    run_frame(1, 1'b0, 1);

    // Long hold with a frame request and a clear during HOLD
    score_mode = 0;
    run_frame(20, 1'b1, -1);

    // Silent network: timeout, late drain, clear
    net_mode = 1;
    tick();
    frame_go   = 1'b1;
    src_budget = src_budget + FL;
    tick();
    frame_go = 1'b0;
    n = 0;
    while (!timeout_o && n < 3000) begin
      tick();
      n++;
    end
    check("timeout_reached", 256'(timeout_o), 256'(1));
    check("wait_cycles", 256'(cyc - last_xfer_cyc - 1), 256'(TMO));
    check("busy_in_err", 256'(busy_o), 256'(1));
    late_req++;
    tick();
    check("late_vector_yumi", 256'(net_yumi_o), 256'(net_valid));
    check("late_vector_driven", 256'(net_valid), 256'(1));
    check("no_result_in_err", 256'(res_valid_o), 256'(0));
    tick();
    tick();
    check("err_holds", 256'(timeout_o), 256'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cleared_busy", 256'(busy_o), 256'(0));
    check("cleared_timeout", 256'(timeout_o), 256'(0));
    check("count_after_err", 256'(frame_count_o), 256'(frames_done));
    net_mode = 0;

    // Reset in the middle of a stream, then a complete frame
    tick();
    frame_go   = 1'b1;
    src_budget = src_budget + FL;
    tick();
    frame_go = 1'b0;
    n = 0;
    while (mon_xfer < 100 && n < 3000) begin
      tick();
      n++;
    end
    check("reached_word_100", 256'(mon_xfer >= 100), 256'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("midstream_reset_outputs", all_outputs(), 256'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    frames_done = '0;
    tick();
    run_frame(1, 1'b0, -1);
    run_frame(0, 1'b0, -1);

    repeat (3) tick();
    check("final_frame_count", 256'(frame_count_o), 256'(frames_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
